// File: rtl/conf_int_mul_prod_accum_pkg.sv
// Shared constants for the multiplier product accumulator: FSM encoding,
// element counter width and default sizing for the mul+accum wrapper.
package conf_int_mul_prod_accum_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int CNT_W            = 8;
    localparam int DEF_ACC_BITWIDTH = 32;
    localparam int DEF_ACC_LEN      = 8;

endpackage

// File: rtl/conf_int_acc_add.sv
// Accumulator adder with carry-out; kept separate so approximate adder
// variants can be dropped in without touching the control logic.
module conf_int_acc_add #(
    parameter int ACC_BITWIDTH = 32
) (
    input  logic [ACC_BITWIDTH-1:0] a_i,
    input  logic [ACC_BITWIDTH-1:0] b_i,
    output logic [ACC_BITWIDTH-1:0] sum_o,
    output logic                    carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/conf_int_mul_prod_accum.sv
// Sums groups of unsigned multiplier products (closed by count or in_last)
// and presents sum, count and sticky overflow on a held output handshake.
module conf_int_mul_prod_accum
    import conf_int_mul_prod_accum_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_BITWIDTH       = DEF_ACC_BITWIDTH,
    parameter int ACC_LEN            = DEF_ACC_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] prod,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_BITWIDTH-1:0]       acc_out,
    output logic [CNT_W-1:0]              out_count,
    output logic                          out_ovf
);

    logic [1:0]              state_q, state_d;
    logic [ACC_BITWIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACC_BITWIDTH-1:0] acc_out_q, acc_out_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_ovf_q, out_ovf_d;

    logic                    accept;
    logic                    in_first;
    logic                    close;
    logic                    carry;
    logic                    ovf_next;
    logic [ACC_BITWIDTH-1:0] acc_base;
    logic [ACC_BITWIDTH-1:0] prod_ext;
    logic [ACC_BITWIDTH-1:0] acc_sum;
    logic [CNT_W-1:0]        cnt_next;

    // Ready is a pure state decode, forced low while reset is asserted.
    assign in_ready = rst & (state_q != ST_HOLD);
    assign accept   = in_valid & in_ready;
    assign in_first = (state_q == ST_IDLE);
    assign acc_base = in_first ? '0 : acc_q;
    assign prod_ext = ACC_BITWIDTH'(prod);
    assign cnt_next = (in_first ? '0 : cnt_q) + CNT_W'(1);
    assign close    = in_last | (cnt_next == CNT_W'(ACC_LEN));
    assign ovf_next = (in_first ? 1'b0 : ovf_q) | carry;

    conf_int_acc_add #(
        .ACC_BITWIDTH(ACC_BITWIDTH)
    ) u_add (
        .a_i    (acc_base),
        .b_i    (prod_ext),
        .sum_o  (acc_sum),
        .carry_o(carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_next;
                    ovf_d = ovf_next;
                    if (close) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        acc_out_d   = acc_sum;
                        out_count_d = cnt_next;
                        out_ovf_d   = ovf_next;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_conf_int_mul_prod_accum.sv
// Bench for the product accumulator: three instances (default, 16-bit
// accumulator, single-element groups) driven and checked against group sums.
module tb_conf_int_mul_prod_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_r [3];
    logic [15:0] prod_r     [3];
    logic        in_last_r  [3];
    logic        out_ready_r[3];

    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic [31:0] acc_out_w  [3];
    logic [7:0]  out_count_w[3];
    logic        out_ovf_w  [3];
    logic [15:0] acc16;

    int accw[3] = '{32, 16, 32};
    int alen[3] = '{8, 8, 1};

    int     checks = 0;
    int     errors = 0;
    longint acc_time = 0;

    always #5 clk = ~clk;

    assign acc_out_w[1] = {16'h0000, acc16};

    conf_int_mul_prod_accum #(.DATA_PATH_BITWIDTH(16), .ACC_BITWIDTH(32), .ACC_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
        .prod(prod_r[0]), .in_last(in_last_r[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_r[0]), .acc_out(acc_out_w[0]), .out_count(out_count_w[0]),
        .out_ovf(out_ovf_w[0]));

    conf_int_mul_prod_accum #(.DATA_PATH_BITWIDTH(16), .ACC_BITWIDTH(16), .ACC_LEN(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
        .prod(prod_r[1]), .in_last(in_last_r[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_r[1]), .acc_out(acc16), .out_count(out_count_w[1]),
        .out_ovf(out_ovf_w[1]));

    conf_int_mul_prod_accum #(.DATA_PATH_BITWIDTH(16), .ACC_BITWIDTH(32), .ACC_LEN(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]),
        .prod(prod_r[2]), .in_last(in_last_r[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_r[2]), .acc_out(acc_out_w[2]), .out_count(out_count_w[2]),
        .out_ovf(out_ovf_w[2]));

    // Present one element at the current falling edge and hold it until taken.
    task automatic send(input int d, input logic [15:0] p, input logic last);
        int w = 0;
        in_valid_r[d] = 1'b1;
        prod_r[d]     = p;
        in_last_r[d]  = last;
        while (in_ready_w[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready=%b after %0d cycles, required 1", d, in_ready_w[d], w);
        end else begin
            @(posedge clk);
            acc_time = $time;
        end
        @(negedge clk);
        in_valid_r[d] = 1'b0;
        in_last_r[d]  = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks += 3;
            if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b, required 0", d, out_valid_w[d]); end
            if (in_ready_w[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b, required 0", d, in_ready_w[d]); end
            if (acc_out_w[d] !== 32'd0) begin errors++; $display("FAIL reset_acc dut%0d: got %0d, required 0", d, acc_out_w[d]); end
        end
        checks += 2;
        if (out_count_w[0] !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", out_count_w[0]); end
        if (out_ovf_w[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", out_ovf_w[0]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b, required 1", in_ready_w[0]); end
    endtask

    task automatic test_full_group();
        out_ready_r[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(0, 16'd3, 1'b0);
            if (i < 7) begin
                checks++;
                if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL full_early_valid elem %0d: got %b, required 0", i, out_valid_w[0]); end
            end
        end
        checks += 4;
        if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL full_valid: got %b, required 1", out_valid_w[0]); end
        if (acc_out_w[0] !== 32'd24) begin errors++; $display("FAIL full_acc: got %0d, required 24", acc_out_w[0]); end
        if (out_count_w[0] !== 8'd8) begin errors++; $display("FAIL full_count: got %0d, required 8", out_count_w[0]); end
        if (out_ovf_w[0] !== 1'b0) begin errors++; $display("FAIL full_ovf: got %b, required 0", out_ovf_w[0]); end
        @(negedge clk);
        checks += 2;
        if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL full_valid_drop: got %b, required 0", out_valid_w[0]); end
        if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b, required 1", in_ready_w[0]); end
    endtask

    task automatic test_early_last();
        out_ready_r[0] = 1'b1;
        send(0, 16'd100, 1'b0);
        send(0, 16'd200, 1'b0);
        send(0, 16'd300, 1'b1);
        checks += 3;
        if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL last_valid: got %b, required 1", out_valid_w[0]); end
        if (acc_out_w[0] !== 32'd600) begin errors++; $display("FAIL last_acc: got %0d, required 600", acc_out_w[0]); end
        if (out_count_w[0] !== 8'd3) begin errors++; $display("FAIL last_count: got %0d, required 3", out_count_w[0]); end
        @(negedge clk);
        send(0, 16'd5, 1'b1);
        checks += 2;
        if (acc_out_w[0] !== 32'd5) begin errors++; $display("FAIL single_acc: got %0d, required 5", acc_out_w[0]); end
        if (out_count_w[0] !== 8'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", out_count_w[0]); end
        @(negedge clk);
    endtask

    task automatic test_hold();
        out_ready_r[0] = 1'b1;
        for (int i = 0; i < 7; i++) send(0, 16'd10, 1'b0);
        out_ready_r[0] = 1'b0;
        send(0, 16'd10, 1'b0);
        in_valid_r[0] = 1'b1;
        prod_r[0]     = 16'd9;
        in_last_r[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks += 4;
            if (in_ready_w[0] !== 1'b0) begin errors++; $display("FAIL hold_ready cyc %0d: got %b, required 0", i, in_ready_w[0]); end
            if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d: got %b, required 1", i, out_valid_w[0]); end
            if (acc_out_w[0] !== 32'd80) begin errors++; $display("FAIL hold_acc cyc %0d: got %0d, required 80", i, acc_out_w[0]); end
            if (out_count_w[0] !== 8'd8) begin errors++; $display("FAIL hold_count cyc %0d: got %0d, required 8", i, out_count_w[0]); end
        end
        out_ready_r[0] = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b, required 0", out_valid_w[0]); end
        if (in_ready_w[0] !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b, required 1", in_ready_w[0]); end
        @(negedge clk);
        in_valid_r[0] = 1'b0;
        in_last_r[0]  = 1'b0;
        checks += 3;
        if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL after_hold_valid: got %b, required 1", out_valid_w[0]); end
        if (acc_out_w[0] !== 32'd9) begin errors++; $display("FAIL after_hold_acc: got %0d, required 9", acc_out_w[0]); end
        if (out_count_w[0] !== 8'd1) begin errors++; $display("FAIL after_hold_count: got %0d, required 1", out_count_w[0]); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        out_ready_r[1] = 1'b1;
        send(1, 16'hFFFF, 1'b0);
        send(1, 16'h0002, 1'b1);
        checks += 3;
        if (acc_out_w[1] !== 32'h0001) begin errors++; $display("FAIL ovf_acc: got %h, required 0001", acc_out_w[1]); end
        if (out_ovf_w[1] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", out_ovf_w[1]); end
        if (out_count_w[1] !== 8'd2) begin errors++; $display("FAIL ovf_count: got %0d, required 2", out_count_w[1]); end
        @(negedge clk);
        send(1, 16'h0005, 1'b1);
        checks += 2;
        if (acc_out_w[1] !== 32'h0005) begin errors++; $display("FAIL ovf_next_acc: got %h, required 0005", acc_out_w[1]); end
        if (out_ovf_w[1] !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %b, required 0", out_ovf_w[1]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready_r[0] = 1'b1;
        for (int i = 0; i < 3; i++) send(0, 16'd7, 1'b0);
        #1 rst = 1'b0;
        #1;
        checks += 2;
        if (in_ready_w[0] !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, required 0", in_ready_w[0]); end
        if (out_count_w[0] !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d, required 0", out_count_w[0]); end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_w[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid_w[0]); end
        for (int i = 0; i < 8; i++) send(0, 16'd1, 1'b0);
        checks += 3;
        if (out_valid_w[0] !== 1'b1) begin errors++; $display("FAIL midrst_res_valid: got %b, required 1", out_valid_w[0]); end
        if (acc_out_w[0] !== 32'd8) begin errors++; $display("FAIL midrst_acc: got %0d, required 8", acc_out_w[0]); end
        if (out_count_w[0] !== 8'd8) begin errors++; $display("FAIL midrst_res_count: got %0d, required 8", out_count_w[0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        longint prev = 0;
        out_ready_r[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = 16'($urandom);
            send(2, p, 1'b0);
            checks += 4;
            if (out_valid_w[2] !== 1'b1) begin errors++; $display("FAIL b2b_valid %0d: got %b, required 1", i, out_valid_w[2]); end
            if (acc_out_w[2] !== {16'h0, p}) begin errors++; $display("FAIL b2b_acc %0d: got %0d, required %0d", i, acc_out_w[2], p); end
            if (out_count_w[2] !== 8'd1) begin errors++; $display("FAIL b2b_count %0d: got %0d, required 1", i, out_count_w[2]); end
            if (in_ready_w[2] !== 1'b0) begin errors++; $display("FAIL b2b_ready %0d: got %b, required 0", i, in_ready_w[2]); end
            if (i > 0) begin
                checks++;
                if (acc_time - prev != 20) begin errors++; $display("FAIL b2b_spacing %0d: got %0d, required 20", i, acc_time - prev); end
            end
            prev = acc_time;
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int d, input int nelem);
        longint      sum = 0;
        longint      mask;
        int          n = 0;
        int          k;
        logic [15:0] p;
        logic        last;
        logic        stall;
        logic [31:0] exp_acc;
        mask = (longint'(1) << accw[d]) - 1;
        for (int i = 0; i < nelem; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            p     = 16'($urandom);
            last  = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 1) == 1);
            sum  += longint'(p);
            n++;
            if (last || n == alen[d]) begin
                exp_acc = 32'(sum & mask);
                out_ready_r[d] = !stall;
                send(d, p, last);
                checks += 4;
                if (out_valid_w[d] !== 1'b1) begin errors++; $display("FAIL rnd_valid dut%0d el %0d: got %b, required 1", d, i, out_valid_w[d]); end
                if (acc_out_w[d] !== exp_acc) begin errors++; $display("FAIL rnd_acc dut%0d el %0d: got %h, required %h", d, i, acc_out_w[d], exp_acc); end
                if (out_count_w[d] !== 8'(n)) begin errors++; $display("FAIL rnd_count dut%0d el %0d: got %0d, required %0d", d, i, out_count_w[d], n); end
                if (out_ovf_w[d] !== (sum > mask)) begin errors++; $display("FAIL rnd_ovf dut%0d el %0d: got %b, required %b", d, i, out_ovf_w[d], sum > mask); end
                if (stall) begin
                    k = $urandom_range(1, 3);
                    repeat (k) begin
                        @(negedge clk);
                        checks += 2;
                        if (in_ready_w[d] !== 1'b0) begin errors++; $display("FAIL rnd_stall_ready dut%0d: got %b, required 0", d, in_ready_w[d]); end
                        if (acc_out_w[d] !== exp_acc) begin errors++; $display("FAIL rnd_stall_acc dut%0d: got %h, required %h", d, acc_out_w[d], exp_acc); end
                    end
                    out_ready_r[d] = 1'b1;
                end
                @(negedge clk);
                checks++;
                if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL rnd_drop dut%0d el %0d: got %b, required 0", d, i, out_valid_w[d]); end
                sum = 0;
                n   = 0;
            end else begin
                out_ready_r[d] = 1'($urandom_range(0, 1));
                send(d, p, last);
                checks++;
                if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL rnd_open_valid dut%0d el %0d: got %b, required 0", d, i, out_valid_w[d]); end
            end
        end
        out_ready_r[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid_r[d]  = 1'b0;
            prod_r[d]      = 16'd0;
            in_last_r[d]   = 1'b0;
            out_ready_r[d] = 1'b0;
        end
        test_reset();
        test_full_group();
        test_early_last();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random(0, 60);
        test_random(1, 60);
        test_random(2, 30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_int_mul_prod_accum.md
Name: conf_int_mul_prod_accum

Overview:
Accumulation stage that sits directly downstream of the configurable integer multiplier. It consumes the truncated product word d over a valid/ready handshake and sums a group of ACC_LEN products, or fewer if the group is closed early by in_last. It presents the group sum, element count and overflow flag on a held output handshake. This turns the combinational multiplier into a multiply-accumulate datapath for dot-product style kernels.

Parameters:
DATA_PATH_BITWIDTH, 16, width of the incoming product word (equals the multiplier's d width)
ACC_BITWIDTH, 32, accumulator/result width; must be >= DATA_PATH_BITWIDTH
ACC_LEN, 8, products per group before automatic close; legal range 1..255

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  prod is valid this cycle
in_ready  output  1  stage can accept a product this cycle
prod  input  DATA_PATH_BITWIDTH  product word from the multiplier, treated as unsigned
in_last  input  1  qualifies prod; closes the group after this element
out_valid  output  1  acc_out/out_count/out_ovf are valid
out_ready  input  1  downstream accepts the result
acc_out  output  ACC_BITWIDTH  group sum, modulo 2^ACC_BITWIDTH
out_count  output  8  number of products in the group (1..ACC_LEN)
out_ovf  output  1  sticky: a carry out of ACC_BITWIDTH occurred in this group

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, cnt=0, ovf=0. Outputs: out_valid=0, acc_out=0, out_count=0, out_ovf=0, in_ready=0 while rst=0.
- Reset mid-group or mid-HOLD discards the partial or pending result. Nothing is emitted after release.
- States: IDLE (no element yet), ACCUM (group open), HOLD (result pending).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a registered-state decode only and does not depend on in_valid or out_ready.
- Accept = in_valid & in_ready. Each accept:
  - adds acc_next = acc + zero-extend(prod) at ACC_BITWIDTH+1 bits;
  - sets ovf |= carry bit;
  - sets cnt += 1.
- In IDLE the accumulator base is 0 and ovf is cleared, so the first element loads prod directly.
- Transitions:
  - IDLE -accept-> ACCUM, or HOLD if in_last or ACC_LEN==1.
  - ACCUM -accept with (cnt+1==ACC_LEN or in_last)-> HOLD.
  - HOLD -out_ready-> IDLE.
- Entering HOLD registers acc_out, out_count and out_ovf, and sets out_valid=1 in the following cycle.
- Latency: result valid 1 cycle after the closing accept.
- In HOLD, outputs are stable until out_ready=1. On that edge out_valid drops to 0 and the internal acc/cnt/ovf clear.
- The next element can be accepted no earlier than the cycle after the handshake (no bypass; 1 bubble per group).
- in_valid=1 during HOLD is not accepted; upstream must hold prod and in_last stable.
- out_ready while out_valid=0 is ignored.
- in_last on an element that also reaches ACC_LEN closes the group once, with no empty group generated.
- Width rule: acc wraps modulo 2^ACC_BITWIDTH. The overflow flag is sticky per group only.
- No X propagation: all outputs are registered except in_ready.

Decomposition:
- Shared header/package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - the count width constant CNT_W=8;
  - default ACC_BITWIDTH/ACC_LEN for use by the mul+accum wrapper.
- One natural sub-module: conf_int_acc_add, a parameterised ACC_BITWIDTH adder with carry-out. It lets approximate adder variants be swapped in later.
- FSM, counter and output registers stay in the top.

Test Plan:
- Reset then 8 accepts of prod=3, in_last=0, out_ready=1 -> one result with acc_out=24, out_count=8, out_ovf=0, out_valid high for exactly 1 cycle, 1 cycle after the 8th accept.
- prod=100, 200, 300 with in_last on the 3rd -> acc_out=600, out_count=3. The next group starts from 0: a single prod=5 with in_last gives 5.
- out_ready=0 for 4 cycles after result with in_valid=1 -> in_ready=0, outputs held constant. Release out_ready -> result consumed and the next prod is accepted the following cycle.
- ACC_BITWIDTH=16, DATA_PATH_BITWIDTH=16, prod=16'hFFFF then 16'h0002 with in_last -> acc_out=16'h0001, out_ovf=1. The next group has out_ovf=0.
- Assert rst=0 asynchronously after 3 accepts, release, then 8 accepts of prod=1 -> single result acc_out=8, out_count=8 (no stale partial sum).
- ACC_LEN=1 with back-to-back in_valid and out_ready=1 -> each element produces its own result, with one bubble cycle between accepts.
